// File: rtl/maxnet_pkg.sv
// Shared definitions for the parametrised Maxnet winner-take-all engine.
// Holds the controller state type, width helpers used to size the datapath,
// and the inhibition-weight legality check applied when the top elaborates.
package maxnet_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

   // Activation width: input value with FRAC fractional bits appended.
   function automatic int unsigned calc_aw(input int unsigned w, input int unsigned frac);
      return w + frac;
   endfunction

   // Channel index width (at least one bit).
   function automatic int unsigned calc_idxw(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Sum width: wide enough for the total of all N activations.
   function automatic int unsigned calc_sw(input int unsigned n, input int unsigned w,
                                           input int unsigned frac);
      return calc_aw(w, frac) + calc_idxw(n);
   endfunction

   // Width of a count that ranges 0..n.
   function automatic int unsigned calc_cntw(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Iteration counter width, able to hold MAX_ITER itself.
   function automatic int unsigned calc_iterw(input int unsigned max_iter);
      return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
   endfunction

   // The summed inhibition of N-1 rivals must stay below a channel's own
   // activation when all are equal, otherwise every channel dies at once.
   function automatic bit eps_ok(input int unsigned n, input int unsigned eps_shift);
      return (64'(1) << eps_shift) > 64'(n - 1);
   endfunction

endpackage

// File: rtl/maxnet_argmax.sv
// Combinational N-way maximum with lowest-index tiebreak.
// Ports:
//   val_i  packed values, value i = val_i[i*VW +: VW]
//   idx_o  index of the largest nonzero value (0 when all are zero)
//   nz_o   number of nonzero values
module maxnet_argmax
   import maxnet_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned VW = 9
) (
   input  logic [N*VW-1:0]         val_i,
   output logic [calc_idxw(N)-1:0] idx_o,
   output logic [calc_cntw(N)-1:0] nz_o
);

   localparam int unsigned IdxW = calc_idxw(N);
   localparam int unsigned CntW = calc_cntw(N);

   logic [VW-1:0] best_val;

   // Strict '>' keeps the earliest index on equal values, and a zero
   // starting best means zero-valued channels never win.
   always_comb begin
      best_val = '0;
      idx_o    = '0;
      nz_o     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (val_i[i*VW +: VW] != '0) begin
            nz_o = nz_o + CntW'(1);
         end
         if (val_i[i*VW +: VW] > best_val) begin
            best_val = val_i[i*VW +: VW];
            idx_o    = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/maxnet_param.sv
// Parametrised Maxnet winner-take-all engine.
// Latches N unsigned W-bit channels on a rising start, then runs one parallel
// lateral-inhibition step per clock until at most one channel survives, the
// activations stop changing, or MAX_ITER steps have been applied.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   start_i         run request, rising-edge qualified, honoured only when idle
//   x_in_i          packed inputs, channel i = x_in_i[i*W +: W]
//   busy_o          high from LOAD through DONE
//   done_o          one-cycle pulse while fresh results are presented
//   result_o        original input value of the winner
//   winner_idx_o    winner channel index
//   valid_o         at least one survivor
//   tie_o           stopped by stall with two or more survivors
//   timeout_o       stopped by the iteration limit with two or more survivors
module maxnet_param
   import maxnet_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned W         = 5,
   parameter int unsigned FRAC      = 4,
   parameter int unsigned EPS_SHIFT = 3,
   parameter int unsigned MAX_ITER  = 63
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [N*W-1:0]          x_in_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [W-1:0]            result_o,
   output logic [calc_idxw(N)-1:0] winner_idx_o,
   output logic                    valid_o,
   output logic                    tie_o,
   output logic                    timeout_o
);

   localparam int unsigned AW    = calc_aw(W, FRAC);
   localparam int unsigned SW    = calc_sw(N, W, FRAC);
   localparam int unsigned IdxW  = calc_idxw(N);
   localparam int unsigned CntW  = calc_cntw(N);
   localparam int unsigned IterW = calc_iterw(MAX_ITER);
   localparam logic [IterW-1:0] MaxIterV = IterW'(MAX_ITER);

   if (N < 2) begin : g_n_bad
      $error("maxnet_param: N must be at least 2");
   end
   if (!eps_ok(N, EPS_SHIFT)) begin : g_eps_bad
      $error("maxnet_param: 2**EPS_SHIFT must exceed N-1");
   end

   state_e              state_q, state_d;
   logic                start_prev_q;
   logic [N*W-1:0]      xq_q;
   logic [N*AW-1:0]     act_q, act_upd;
   logic [IterW-1:0]    iter_q;
   logic                stall_q;
   logic [W-1:0]        result_q;
   logic [IdxW-1:0]     idx_q;
   logic                valid_q, tie_q, timeout_q;

   logic [SW-1:0]       sum, a_ext, inh;
   logic                any_change;
   logic [IdxW-1:0]     win_idx;
   logic [CntW-1:0]     nz;
   logic                start_rise, finish;

   maxnet_argmax #(
      .N  (N),
      .VW (AW)
   ) u_argmax (
      .val_i (act_q),
      .idx_o (win_idx),
      .nz_o  (nz)
   );

   assign start_rise = start_i & ~start_prev_q;
   assign finish     = (nz <= CntW'(1)) || stall_q || (iter_q == MaxIterV);

   // One inhibition step for all channels in parallel.
   always_comb begin
      sum        = '0;
      a_ext      = '0;
      inh        = '0;
      act_upd    = '0;
      any_change = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = sum + SW'(act_q[i*AW +: AW]);
      end
      for (int unsigned i = 0; i < N; i++) begin
         a_ext = SW'(act_q[i*AW +: AW]);
         inh   = (sum - a_ext) >> EPS_SHIFT;
         if (inh >= a_ext) begin
            act_upd[i*AW +: AW] = '0;
         end else begin
            // inh < a_ext here, so its low AW bits carry the whole value.
            act_upd[i*AW +: AW] = act_q[i*AW +: AW] - inh[AW-1:0];
         end
         if (act_upd[i*AW +: AW] != act_q[i*AW +: AW]) begin
            any_change = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_rise) state_d = StLoad;
         StLoad:  state_d = StIter;
         StIter:  if (finish) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o = (state_q != StIdle);
      done_o = (state_q == StDone);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         start_prev_q <= 1'b0;
         xq_q         <= '0;
         act_q        <= '0;
         iter_q       <= '0;
         stall_q      <= 1'b0;
         result_q     <= '0;
         idx_q        <= '0;
         valid_q      <= 1'b0;
         tie_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         start_prev_q <= start_i;
         case (state_q)
            StLoad: begin
               xq_q <= x_in_i;
               for (int unsigned i = 0; i < N; i++) begin
                  act_q[i*AW +: AW] <= AW'(x_in_i[i*W +: W]) << FRAC;
               end
               iter_q  <= '0;
               stall_q <= 1'b0;
            end
            StIter: begin
               if (finish) begin
                  // Results land here so they are already valid during DONE.
                  result_q  <= (nz != '0) ? xq_q[win_idx*W +: W] : '0;
                  idx_q     <= (nz != '0) ? win_idx : '0;
                  valid_q   <= (nz != '0);
                  tie_q     <= (nz >= CntW'(2)) && stall_q;
                  timeout_q <= (nz >= CntW'(2)) && !stall_q && (iter_q == MaxIterV);
               end else begin
                  act_q   <= act_upd;
                  iter_q  <= iter_q + IterW'(1);
                  stall_q <= !any_change;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o     = result_q;
   assign winner_idx_o = idx_q;
   assign valid_o      = valid_q;
   assign tie_o        = tie_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Bench for maxnet_param: two instances (MAX_ITER 63 and 2) share stimulus and
// are compared every cycle against an integer model of the Maxnet rules.
module tb_maxnet_param;

   localparam int unsigned N    = 4;
   localparam int unsigned W    = 5;
   localparam int unsigned FRAC = 4;
   localparam int unsigned EPS  = 3;

   typedef struct packed {
      logic [W-1:0] res;
      logic [1:0]   idx;
      logic         vld;
      logic         tie;
      logic         tmo;
      logic [31:0]  u;
   } run_t;

   logic           clk   = 1'b0;
   logic           rst   = 1'b1;
   logic           start = 1'b0;
   logic [N*W-1:0] x_in  = '0;

   logic           busy [2];
   logic           done [2];
   logic [W-1:0]   res  [2];
   logic [1:0]     idx  [2];
   logic           vld  [2];
   logic           tie  [2];
   logic           tmo  [2];

   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   int   m_cnt  [2];
   bit   m_load [2];
   bit   m_sp   [2];
   run_t p_run  [2];
   run_t e_run  [2];

   always #5 clk = ~clk;

   maxnet_param #(.N(N), .W(W), .FRAC(FRAC), .EPS_SHIFT(EPS), .MAX_ITER(63)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .x_in_i(x_in),
      .busy_o(busy[0]), .done_o(done[0]), .result_o(res[0]), .winner_idx_o(idx[0]),
      .valid_o(vld[0]), .tie_o(tie[0]), .timeout_o(tmo[0])
   );

   maxnet_param #(.N(N), .W(W), .FRAC(FRAC), .EPS_SHIFT(EPS), .MAX_ITER(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .x_in_i(x_in),
      .busy_o(busy[1]), .done_o(done[1]), .result_o(res[1]), .winner_idx_o(idx[1]),
      .valid_o(vld[1]), .tie_o(tie[1]), .timeout_o(tmo[1])
   );

   function automatic int max_iter_of(input int d);
      return (d == 0) ? 63 : 2;
   endfunction

   function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2,
                                            input int c3);
      return {W'(c3), W'(c2), W'(c1), W'(c0)};
   endfunction

   // Whole run computed in plain integers from the Maxnet rules.
   function automatic run_t model_run(input logic [N*W-1:0] x, input int maxit);
      run_t r;
      int   a [N];
      int   an [N];
      int   s, nz, it, best, win, inh;
      bit   st, ch, fin;
      for (int i = 0; i < N; i++) a[i] = int'(x[i*W +: W]) * (1 << FRAC);
      it = 0; st = 1'b0; fin = 1'b0; r = '0;
      while (!fin) begin
         nz = 0;
         for (int i = 0; i < N; i++) if (a[i] != 0) nz++;
         if (nz <= 1 || st || it == maxit) begin
            fin = 1'b1;
         end else begin
            s = 0;
            for (int i = 0; i < N; i++) s += a[i];
            ch = 1'b0;
            for (int i = 0; i < N; i++) begin
               inh   = (s - a[i]) / (1 << EPS);
               an[i] = (inh >= a[i]) ? 0 : a[i] - inh;
               if (an[i] != a[i]) ch = 1'b1;
            end
            for (int i = 0; i < N; i++) a[i] = an[i];
            st = !ch;
            it++;
            r.u = r.u + 1;
         end
      end
      best = 0; win = 0;
      for (int i = 0; i < N; i++) begin
         if (a[i] > best) begin
            best = a[i];
            win  = i;
         end
      end
      r.vld = (nz >= 1);
      r.idx = r.vld ? 2'(win) : 2'd0;
      r.res = r.vld ? x[win*W +: W] : '0;
      r.tie = (nz >= 2) && st;
      r.tmo = (nz >= 2) && !st && (it == maxit);
      return r;
   endfunction

   function automatic int exp_updates(input logic [N*W-1:0] x, input int maxit);
      run_t r;
      r = model_run(x, maxit);
      return int'(r.u);
   endfunction

   // Cycle-level view: a qualified start opens a LOAD cycle; at the end of LOAD
   // the run length is known and busy lasts 2+U more cycles, the last being DONE.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_cnt[d]  <= 0;
            m_load[d] <= 1'b0;
            m_sp[d]   <= 1'b0;
            e_run[d]  <= '0;
         end else begin
            m_sp[d] <= start;
            if (m_load[d]) begin
               p_run[d]  <= model_run(x_in, max_iter_of(d));
               m_cnt[d]  <= 2 + exp_updates(x_in, max_iter_of(d));
               m_load[d] <= 1'b0;
            end else if (m_cnt[d] > 0) begin
               m_cnt[d] <= m_cnt[d] - 1;
               if (m_cnt[d] == 2) e_run[d] <= p_run[d];
            end else if (start && !m_sp[d]) begin
               m_load[d] <= 1'b1;
            end
         end
      end
   end

   function automatic logic [11:0] dut_vec(input int d);
      return {busy[d], done[d], res[d], idx[d], vld[d], tie[d], tmo[d]};
   endfunction

   function automatic logic [11:0] exp_vec(input int d);
      logic b, dn;
      b  = m_load[d] || (m_cnt[d] > 0);
      dn = !m_load[d] && (m_cnt[d] == 1);
      return {b, dn, e_run[d].res, e_run[d].idx, e_run[d].vld, e_run[d].tie, e_run[d].tmo};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_expired(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired, got no event, expected one", name);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_run(input logic [N*W-1:0] x, input int hold);
      @(negedge clk);
      x_in  = x;
      start = 1'b1;
      repeat (hold) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d, input string name);
      int n;
      n = 0;
      while (!done[d] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done[d]) bound_expired(name);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_load[0] || m_cnt[0] > 0 || m_load[1] || m_cnt[1] > 0 || busy[0] || busy[1])
             && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) bound_expired("wait_idle");
   endtask

   task automatic zero_latency(input logic [N*W-1:0] x, input string name, output int n);
      @(negedge clk);
      x_in  = x;
      start = 1'b1;
      n     = 0;
      while (!done[0] && n < 20) begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      start = 1'b0;
      check(name, n, 3);
   endtask

   task automatic stimulus();
      run_t r;
      int   n, dcount, mode, dly;
      logic [N*W-1:0] xr;
      logic [N*W-1:0] seq_x [3];
      int   seq_idx [3];
      int   seq_res [3];

      // Model pinned against hand-worked cases.
      r = model_run(pack4(5, 5, 0, 0), 63);
      check("pin_stall_updates", int'(r.u), 23);
      check("pin_stall_tie", int'(r.tie), 1);
      check("pin_stall_res", int'(r.res), 5);
      r = model_run(pack4(1, 2, 3, 4), 2);
      check("pin_limit_tmo", int'(r.tmo), 1);
      check("pin_limit_updates", int'(r.u), 2);
      check("pin_limit_idx", int'(r.idx), 3);

      reset_dut();
      chk_en = 1'b1;
      check("reset_res", int'(res[0]), 0);
      check("reset_busy", int'(busy[0]), 0);

      // Start held two cycles: one run on each instance.
      start_run(pack4(1, 2, 3, 4), 2);
      wait_done(1, "done_limit");
      check("limit_tmo", int'(tmo[1]), 1);
      check("limit_idx", int'(idx[1]), 3);
      check("limit_res", int'(res[1]), 4);
      wait_done(0, "done_basic");
      check("basic_idx", int'(idx[0]), 3);
      check("basic_res", int'(res[0]), 4);
      check("basic_flags", int'({vld[0], tie[0], tmo[0]}), 3'b100);
      @(negedge clk);
      check("basic_busy_after", int'(busy[0]), 0);
      wait_idle();

      seq_x[0] = pack4(7, 2, 1, 4); seq_idx[0] = 0; seq_res[0] = 7;
      seq_x[1] = pack4(3, 6, 7, 4); seq_idx[1] = 2; seq_res[1] = 7;
      seq_x[2] = pack4(7, 5, 5, 4); seq_idx[2] = 0; seq_res[2] = 7;
      for (int i = 0; i < 3; i++) begin
         reset_dut();
         start_run(seq_x[i], 1);
         wait_done(0, "done_seq");
         check("seq_idx", int'(idx[0]), seq_idx[i]);
         check("seq_res", int'(res[0]), seq_res[i]);
         wait_idle();
      end

      start_run(pack4(5, 5, 0, 0), 1);
      wait_done(0, "done_stall");
      check("stall_tie", int'(tie[0]), 1);
      check("stall_idx_res", int'({idx[0], res[0]}), int'({2'd0, 5'd5}));
      check("stall_vld", int'(vld[0]), 1);
      wait_idle();

      zero_latency(pack4(0, 0, 0, 0), "lat_all_zero", n);
      check("all_zero_vld", int'(vld[0]), 0);
      wait_idle();
      zero_latency(pack4(0, 0, 9, 0), "lat_single", n);
      check("single_idx", int'(idx[0]), 2);
      check("single_res", int'(res[0]), 9);
      wait_idle();

      // Reset in the middle of iterating wipes outputs without a done pulse.
      start_run(pack4(5, 5, 0, 0), 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_res", int'(res[0]), 0);
      check("abort_busy", int'(busy[0]), 0);
      start_run(pack4(1, 2, 3, 4), 1);
      wait_done(0, "done_after_abort");
      check("after_abort_res", int'(res[0]), 4);
      wait_idle();

      // Extra start pulse mid-run is ignored.
      start_run(pack4(5, 5, 0, 0), 1);
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      dcount = 0;
      n      = 0;
      while (busy[0] && n < 400) begin
         if (done[0]) dcount++;
         @(negedge clk);
         n++;
      end
      if (busy[0]) bound_expired("busy_ignore");
      check("start_ignored_dones", dcount, 1);
      wait_idle();

      // Input change during ITER has no effect on the run.
      start_run(pack4(5, 5, 0, 0), 1);
      repeat (3) @(negedge clk);
      x_in = pack4(31, 31, 31, 31);
      wait_done(0, "done_xchange");
      check("xchange_res", int'(res[0]), 5);
      check("xchange_tie", int'(tie[0]), 1);
      wait_idle();

      // Randomised runs with occasional aborts, stray starts and input churn.
      for (int it = 0; it < 150; it++) begin
         xr = N*W'($urandom);
         if ($urandom_range(0, 3) == 0) xr[W +: W] = xr[0 +: W];
         if ($urandom_range(0, 3) == 0) xr[2*W +: W] = '0;
         if ($urandom_range(0, 5) == 0) xr[3*W +: W] = xr[2*W +: W];
         start_run(xr, $urandom_range(1, 3));
         mode = $urandom_range(0, 7);
         dly  = $urandom_range(0, 12);
         if (mode == 0) begin
            repeat (dly) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (mode == 1) begin
            repeat (dly) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end else if (mode == 2) begin
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               x_in = N*W'($urandom);
            end
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge clk);
               if (chk_en) begin
                  for (int d = 0; d < 2; d++) begin
                     checks++;
                     if (dut_vec(d) !== exp_vec(d)) begin
                        errors++;
                        $display("FAIL cycle_cmp dut%0d busy,done,res,idx,vld,tie,tmo: got %b expected %b at %0t",
                                 d, dut_vec(d), exp_vec(d), $time);
                     end
                  end
               end
            end
         end
         begin
            stimulus();
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      join_any
   end

endmodule
